// File: rtl/bus_rr_router_pkg.sv
// Shared types and helpers for the round-robin bus router and its arbiter.
package bus_rr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        ROUTE,
        SEND,
        DROP
    } state_e;

    // Index width for n ports; a single port still needs one bit.
    function automatic int unsigned src_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Destination ID is the top id_w bits of a pckg_sz-bit packet.
    function automatic logic [31:0] get_id(input logic [63:0] pkt,
                                           input int unsigned pckg_sz,
                                           input int unsigned id_w);
        return 32'((pkt >> (pckg_sz - id_w)) & ((64'd1 << id_w) - 64'd1));
    endfunction

    function automatic logic is_broadcast(input logic [31:0] id,
                                          input logic [31:0] bcast);
        return id == bcast;
    endfunction

endpackage

// File: rtl/bus_rr_router_rr_arbiter.sv
// Round-robin / fixed-priority grant selection; holds the last-grant pointer.
module rr_arbiter
    import bus_rr_pkg::*;
#(
    parameter int unsigned DRVRS = 4,
    parameter int unsigned SRC_W = src_width(DRVRS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DRVRS-1:0] req,
    input  logic             prio_mode,
    input  logic             en,
    output logic [SRC_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [SRC_W-1:0] r_ptr;
    int unsigned      w_idx;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        w_idx     = 0;
        if (prio_mode) begin
            for (int unsigned i = 0; i < DRVRS; i++) begin
                if (!gnt_valid && req[SRC_W'(i)]) begin
                    gnt_idx   = SRC_W'(i);
                    gnt_valid = 1'b1;
                end
            end
        end else begin
            // Search starts one past the last grant so it gets lowest priority.
            for (int unsigned i = 1; i <= DRVRS; i++) begin
                w_idx = (32'(r_ptr) + i) % DRVRS;
                if (!gnt_valid && req[SRC_W'(w_idx)]) begin
                    gnt_idx   = SRC_W'(w_idx);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= SRC_W'(DRVRS - 1);
        end else if (en && gnt_valid) begin
            r_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/bus_rr_router.sv
// Arbitrates driver FIFO heads onto one bus and routes each packet to a
// destination port or broadcasts it; undeliverable packets are counted.
module bus_rr_router
    import bus_rr_pkg::*;
#(
    parameter int unsigned     DRVRS     = 4,
    parameter int unsigned     PCKG_SZ   = 16,
    parameter int unsigned     ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = ID_W'(8'hFF),
    parameter int unsigned     CNT_W     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            prio_mode,
    input  logic [DRVRS-1:0]                pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]                pop,
    input  logic [DRVRS-1:0]                full,
    output logic [DRVRS-1:0]                push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
    output logic                            busy,
    output logic [CNT_W-1:0]                drop_cnt
);

    localparam int unsigned SRC_W = src_width(DRVRS);

    state_e                        r_state, w_next;
    logic [DRVRS-1:0]              r_pop, w_pop;
    logic [DRVRS-1:0]              r_push, w_push;
    logic [DRVRS-1:0]              r_mask, w_mask;
    logic [DRVRS-1:0][PCKG_SZ-1:0] r_dpush;
    logic [PCKG_SZ-1:0]            r_pkt;
    logic [SRC_W-1:0]              r_gnt, r_src;
    logic [SRC_W-1:0]              w_gnt_idx;
    logic                          w_gnt_valid, w_arb_en;
    logic [ID_W-1:0]               w_dst;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_busy;

    rr_arbiter #(
        .DRVRS (DRVRS),
        .SRC_W (SRC_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (pndng),
        .prio_mode (prio_mode),
        .en        (w_arb_en),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    assign w_dst = ID_W'(get_id(64'(r_pkt), PCKG_SZ, ID_W));

    // push is registered, so the full check runs one cycle ahead of the
    // visible strobe: ROUTE issues it directly when targets are free, SEND
    // otherwise retries every cycle and leaves once the strobe has gone out.
    always_comb begin
        w_next   = r_state;
        w_pop    = '0;
        w_push   = '0;
        w_mask   = r_mask;
        w_arb_en = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_arb_en         = 1'b1;
                    w_pop[w_gnt_idx] = 1'b1;
                    w_next           = POP;
                end
            end
            POP: w_next = ROUTE;
            ROUTE: begin
                w_mask = '0;
                if (is_broadcast(32'(w_dst), 32'(BROADCAST))) begin
                    w_mask        = '1;
                    w_mask[r_src] = 1'b0;
                end else if (32'(w_dst) < DRVRS && 32'(w_dst) != 32'(r_src)) begin
                    w_mask[SRC_W'(w_dst)] = 1'b1;
                end
                if (w_mask == '0) begin
                    w_next = DROP;
                end else begin
                    w_next = SEND;
                    if ((full & w_mask) == '0) w_push = w_mask;
                end
            end
            SEND: begin
                if (r_push != '0) begin
                    w_next = IDLE;
                end else if ((full & r_mask) == '0) begin
                    w_push = r_mask;
                end
            end
            DROP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pop   <= '0;
            r_push  <= '0;
            r_mask  <= '0;
            r_dpush <= '0;
            r_pkt   <= '0;
            r_gnt   <= '0;
            r_src   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pop   <= w_pop;
            r_push  <= w_push;
            r_mask  <= w_mask;
            r_busy  <= (w_next != IDLE);
            if (r_state == IDLE && w_gnt_valid) r_gnt <= w_gnt_idx;
            if (r_state == POP) begin
                r_pkt <= D_pop[r_gnt];
                r_src <= r_gnt;
            end
            for (int unsigned t = 0; t < DRVRS; t++) begin
                if (w_push[t]) r_dpush[t] <= r_pkt;
            end
            if (r_state == DROP && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign pop      = r_pop;
    assign push     = r_push;
    assign D_push   = r_dpush;
    assign busy     = r_busy;
    assign drop_cnt = r_cnt;

endmodule

// File: tb/tb_bus_rr_router.sv
// Scoreboard bench for bus_rr_router: driver FIFO model, grant and push queues.
module tb_bus_rr_router;

    localparam int N = 4;
    localparam int W = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                prio_mode = 1'b0;
    logic [N-1:0]        pndng = '0;
    logic [N-1:0]        full = '0;
    logic [N-1:0][W-1:0] D_pop = '0;
    logic [N-1:0]        pop, push, pop2, push2;
    logic [N-1:0][W-1:0] D_push, D_push2;
    logic                busy, busy2;
    logic [7:0]          drop_cnt;
    logic [1:0]          drop_cnt2;

    bus_rr_router #(.DRVRS(N), .PCKG_SZ(W), .ID_W(8), .BROADCAST(8'hFF), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .prio_mode(prio_mode), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .full(full), .push(push), .D_push(D_push), .busy(busy), .drop_cnt(drop_cnt)
    );

    // Narrow-counter copy in lockstep, used only for saturation.
    bus_rr_router #(.DRVRS(N), .PCKG_SZ(W), .ID_W(8), .BROADCAST(8'hFF), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .prio_mode(prio_mode), .pndng(pndng), .D_pop(D_pop),
        .pop(pop2), .full(full), .push(push2), .D_push(D_push2), .busy(busy2), .drop_cnt(drop_cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] mask;
        logic [W-1:0] data;
    } exp_t;

    exp_t         sbq[$];
    int           gq[$];
    logic [W-1:0] fq[N][$];
    int           n_chk = 0, n_pass = 0, cyc = 0;
    int           push_cnt = 0, pop_cnt = 0, last_push_cyc = 0, busy_fall_cyc = 0;
    int           pop_cyc[N], push_cyc[N];
    logic [N-1:0] pop_pend = '0;
    logic         busy_q = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic expect_pkt(input int g, input logic [W-1:0] pkt, input logic [N-1:0] mask);
        exp_t e;
        gq.push_back(g);
        if (mask != '0) begin
            e.mask = mask;
            e.data = pkt;
            sbq.push_back(e);
        end
    endtask

    task automatic monitor();
        if (pop != '0) begin
            pop_cnt++;
            check("pop_needs_pndng", 64'(pop & ~pndng), 64'd0);
            if (gq.size() == 0) begin
                check("pop_unexpected", 64'(pop), 64'd0);
            end else begin
                int g;
                g = gq.pop_front();
                check("pop_grant", 64'(pop), 64'd1 << g);
            end
            for (int i = 0; i < N; i++) if (pop[i]) pop_cyc[i] = cyc;
        end
        pop_pend = pop;
        if (push != '0) begin
            push_cnt++;
            last_push_cyc = cyc;
            for (int t = 0; t < N; t++) if (push[t]) push_cyc[t] = cyc;
            check("push_vs_full", 64'(push & full), 64'd0);
            if (sbq.size() == 0) begin
                check("push_unexpected", 64'(push), 64'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("push_mask", 64'(push), 64'(e.mask));
                for (int t = 0; t < N; t++)
                    if (e.mask[t]) check("d_push", 64'(D_push[t]), 64'(e.data));
            end
        end
        if (busy_q && !busy) busy_fall_cyc = cyc;
        busy_q = busy;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            pndng[i] = (fq[i].size() != 0);
            D_pop[i] = (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    endtask

    // A popped head leaves the FIFO only after the edge that captured it.
    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++)
            if (pop_pend[i] && fq[i].size() != 0) fq[i].delete(0);
        monitor();
        drive();
    endtask

    function automatic logic all_idle();
        logic e;
        e = 1'b1;
        for (int i = 0; i < N; i++) if (fq[i].size() != 0) e = 1'b0;
        return e && !busy && gq.size() == 0 && sbq.size() == 0 && pop_pend == '0;
    endfunction

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!all_idle() && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_complete"}, 64'(n < 300), 64'd1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int c0, pc;
        logic [W-1:0] pkt;

        tick();
        tick();
        check("rst_pop", 64'(pop), 64'd0);
        check("rst_push", 64'(push), 64'd0);
        check("rst_d_push", 64'(D_push), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        reset = 1'b1;
        tick();

        // Unicast latency
        fq[0].push_back(16'h02AB);
        expect_pkt(0, 16'h02AB, 4'b0100);
        tick();
        c0 = cyc;
        drain("uni");
        check("uni_pop_cycle", 64'(pop_cyc[0] - c0), 64'd1);
        check("uni_push_cycle", 64'(last_push_cyc - c0), 64'd3);
        check("uni_busy_fall", 64'(busy_fall_cyc - c0), 64'd4);

        // Round-robin fairness from a fresh pointer
        do_reset();
        prio_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int d = 0; d < N; d++) begin
                pkt = {(d == 0) ? 8'h01 : 8'h00, 4'(d), 4'(k)};
                fq[d].push_back(pkt);
                expect_pkt(d, pkt, (d == 0) ? 4'b0010 : 4'b0001);
            end
        end
        drain("rr");

        // Fixed priority: driver 0 drains first
        prio_mode = 1'b1;
        for (int d = 0; d < N; d++) begin
            for (int k = 2; k < 4; k++) begin
                pkt = {(d == 0) ? 8'h01 : 8'h00, 4'(d), 4'(k)};
                fq[d].push_back(pkt);
                expect_pkt(d, pkt, (d == 0) ? 4'b0010 : 4'b0001);
            end
        end
        drain("prio");
        prio_mode = 1'b0;

        // Broadcast, then broadcast held by one full target
        fq[1].push_back(16'hFF5A);
        expect_pkt(1, 16'hFF5A, 4'b1101);
        drain("bcast");
        full = 4'b1000;
        fq[1].push_back(16'hFF5B);
        expect_pkt(1, 16'hFF5B, 4'b1101);
        pc = push_cnt;
        repeat (8) tick();
        check("bcast_held", 64'(push_cnt - pc), 64'd0);
        check("bcast_busy_wait", 64'(busy), 64'd1);
        full = '0;
        drain("bcast_full");
        check("bcast_single_push", 64'(push_cnt - pc), 64'd1);

        // Drops: unknown ID, self, then more to saturate the narrow counter
        fq[0].push_back(16'h0711);
        expect_pkt(0, 16'h0711, 4'b0000);
        drain("drop_id");
        check("drop_cnt_1", 64'(drop_cnt), 64'd1);
        fq[0].push_back(16'h0022);
        expect_pkt(0, 16'h0022, 4'b0000);
        drain("drop_self");
        check("drop_cnt_2", 64'(drop_cnt), 64'd2);
        fq[2].push_back(16'h0233);
        expect_pkt(2, 16'h0233, 4'b0000);
        drain("drop3");
        fq[1].push_back(16'h0944);
        expect_pkt(1, 16'h0944, 4'b0000);
        drain("drop4");
        fq[3].push_back(16'h3055);
        expect_pkt(3, 16'h3055, 4'b0000);
        drain("drop5");
        check("drop_cnt_5", 64'(drop_cnt), 64'd5);
        check("drop_cnt_sat", 64'(drop_cnt2), 64'd3);

        // Asynchronous reset while SEND waits on full
        full = 4'b0100;
        fq[0].push_back(16'h0266);
        expect_pkt(0, 16'h0266, 4'b0100);
        repeat (6) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_pop", 64'(pop), 64'd0);
        check("async_rst_push", 64'(push), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_drop_cnt", 64'(drop_cnt), 64'd0);
        sbq.delete();
        gq.delete();
        pop_pend = '0;
        full = '0;
        tick();
        reset = 1'b1;
        for (int d = 0; d < N; d++) begin
            pkt = {8'((d + 1) % N), 8'h90 + 8'(d)};
            fq[d].push_back(pkt);
            expect_pkt(d, pkt, 4'(1 << ((d + 1) % N)));
        end
        drain("post_rst");

        // Backpressure: a new request waits for the blocked unicast
        full = 4'b0100;
        fq[0].push_back(16'h0277);
        expect_pkt(0, 16'h0277, 4'b0100);
        repeat (3) tick();
        pc = pop_cnt;
        fq[3].push_back(16'h0188);
        expect_pkt(3, 16'h0188, 4'b0010);
        repeat (6) tick();
        check("bp_no_pop3", 64'(pop_cnt - pc), 64'd0);
        full = '0;
        drain("bp");
        check("bp_pop3_gap", 64'(pop_cyc[3] - push_cyc[2]), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_rr_router.md
Name: bus_rr_router

Overview:
- Parametrised successor to the single-bus generator/arbiter used by the bushandler environment.
- Arbitrates DRVRS driver FIFOs (pndng/pop/D_pop) onto one shared bus and routes each packet to one destination port, or to all other ports for broadcast.
- Adds selectable round-robin/fixed-priority arbitration, per-destination backpressure (full), and drop handling with a saturating drop counter.
- Sits between the per-driver FIFOs and the destination push interfaces, i.e. exactly where the driver/monitor pair attaches.

Parameters:
- DRVRS, 4, number of driver/destination ports (2..16)
- PCKG_SZ, 16, packet width in bits; the top ID_W bits are the destination ID
- ID_W, 8, destination ID field width (ID_W < PCKG_SZ)
- BROADCAST, 8'hFF, ID value that selects broadcast
- CNT_W, 8, width of drop_cnt

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only in IDLE
- pndng  in  DRVRS  driver i has a packet at its FIFO head; D_pop[i] valid while high
- D_pop  in  DRVRS x PCKG_SZ  FIFO head data per driver
- pop  out  DRVRS  one-cycle dequeue strobe per driver
- full  in  DRVRS  destination i cannot accept a push this cycle
- push  out  DRVRS  one-cycle write strobe per destination
- D_push  out  DRVRS x PCKG_SZ  data per destination; valid with push
- busy  out  1  high in any state other than IDLE
- drop_cnt  out  CNT_W  count of dropped packets; saturates at all-ones

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous) drives pop, push, D_push, busy, and drop_cnt to 0, sets state to IDLE, and sets the RR pointer to DRVRS-1 so driver 0 is favoured first.
- Reset mid-packet discards the captured packet without pushing it; the packet is lost.
- FSM:
  - IDLE: if any pndng is set, compute grant g, assert pop[g] next cycle, go to POP.
  - POP: pop[g]=1 for exactly one cycle; capture D_pop[g] and src=g at the end of the cycle; go to ROUTE.
  - ROUTE: decode dst = pkt[PCKG_SZ-1 -: ID_W].
    - dst == BROADCAST: target mask = all ports except src.
    - dst < DRVRS and dst != src: target mask = one-hot(dst).
    - Otherwise: DROP.
    - Valid target goes to SEND.
  - SEND: wait until every target has full=0 in the same cycle; then assert push on exactly the target mask for one cycle, with D_push[t]=pkt; return to IDLE. No partial broadcast is allowed. Waiting has no timeout.
  - DROP: drop_cnt += 1 (saturating); return to IDLE; no push.
- Arbitration:
  - Round-robin: search from ptr+1, wrapping modulo DRVRS.
  - Fixed priority: lowest set index wins.
  - ptr <= g on every grant, in both modes.
- Minimum latency: pndng seen in IDLE at cycle 0, pop at cycle 1, ROUTE at cycle 2, push at cycle 3. Throughput is at most 1 packet per 4 cycles.
- pndng changing during POP/ROUTE/SEND is ignored until the next IDLE.
- pop is never asserted while pndng[g]=0. The grant is decided only from the IDLE-cycle pndng.
- D_push holds its last value when push=0; the bench must ignore it.

Decomposition:
- Package bus_rr_pkg:
  - state_e {IDLE, POP, ROUTE, SEND, DROP}
  - function get_id(pkt)
  - function is_broadcast(id)
  - localparam SRC_W = $clog2(DRVRS)
- One sub-module, rr_arbiter:
  - Inputs: req[DRVRS], prio_mode, en, clk, reset.
  - Outputs: gnt_idx and gnt_valid.
  - Holds the pointer.
- Top level holds the FSM, packet register, and counter.

Test Plan (DRVRS=4, PCKG_SZ=16, ID_W=8):
- Unicast: pndng=4'b0001, D_pop[0]=16'h02AB, full=0 -> pop[0] at cycle 1; push=4'b0100 with D_push[2]=16'h02AB at cycle 3; busy falls at cycle 4.
- Round-robin fairness: pndng held at 4'b1111, prio_mode=0, all packets to ID 0 (ID 1 from driver 0) -> grant order 0,1,2,3,0; with prio_mode=1 -> always 0.
- Broadcast: driver 1 sends 16'hFF5A -> push=4'b1101 in one cycle, all three D_push=16'hFF5A; with full[3]=1 for 5 cycles -> no push until full[3] drops, then a single push on all three targets.
- Drop: driver 0 sends ID 8'h07, then 8'h00 (self) -> no push, drop_cnt 0->1->2; with CNT_W=2 and 5 bad packets -> drop_cnt saturates at 3.
- Async reset mid-SEND: assert reset=0 between clock edges while waiting on full -> push, pop, busy, and drop_cnt are 0 immediately; after release, pndng=4'b1111 grants driver 0 first.
- Backpressure hold: full[2]=1 while a unicast to 2 waits and pndng[3] rises -> no pop[3] until the push to 2 completes and the FSM is back in IDLE.
